// File: rtl/macc_post_pkg.sv
// Shared helpers for the MACC post-processing stages: saturation bounds and counter sizing.
package macc_post_pkg;

  // Largest signed value representable in w bits.
  function automatic longint SAT_MAX(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint SAT_MIN(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_relu.sv
// Optional ReLU followed by signed clamp to OUT_WIDTH. ReLU is enabled by MACC_POOL_RELU_EN.
module sat_relu
  import macc_post_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  data_i,
  output logic signed [OUT_WIDTH-1:0] data_o
);

  localparam logic signed [IN_WIDTH-1:0] MaxVal = IN_WIDTH'(SAT_MAX(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MinVal = IN_WIDTH'(SAT_MIN(OUT_WIDTH));

  logic signed [IN_WIDTH-1:0] act;

  always_comb begin
`ifdef MACC_POOL_RELU_EN
    act = data_i[IN_WIDTH-1] ? '0 : data_i;
`else
    act = data_i;
`endif
    // In-range values only lose redundant sign bits.
    if (act > MaxVal) begin
      data_o = MaxVal[OUT_WIDTH-1:0];
    end else if (act < MinVal) begin
      data_o = MinVal[OUT_WIDTH-1:0];
    end else begin
      data_o = act[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/macc_pool_act.sv
// Per-lane max-pool, optional ReLU (MACC_POOL_RELU_EN) and saturation with valid/ready output.
`ifndef PRECISION_OP
`define PRECISION_OP 16
`endif

module macc_pool_act
  import macc_post_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = `PRECISION_OP,
  parameter int unsigned OUT_WIDTH = `PRECISION_OP,
  parameter int unsigned POOL_SIZE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int unsigned CntW = (clog2(POOL_SIZE) > 0) ? clog2(POOL_SIZE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(POOL_SIZE - 1);

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic signed [IN_WIDTH-1:0]   max_q, max_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic signed [IN_WIDTH-1:0]   win;
  logic signed [OUT_WIDTH-1:0]  sat_out;
  logic                         accept, close;

  // A stuck result stalls every sample, closing or not.
  assign in_ready = reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt_q == CntLast));
  assign win      = ((cnt_q == '0) || (in_data > max_q)) ? in_data : max_q;

  sat_relu #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_relu (
    .data_i (win),
    .data_o (sat_out)
  );

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      max_d = win;
      cnt_d = close ? '0 : cnt_q + CntW'(1);
    end
    // A close overrides a concurrent drain so results stream without a bubble.
    if (close) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_out;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_macc_pool_act.sv
// Bench for macc_pool_act: directed scenarios plus a randomized stream against a queue model.
module tb_macc_pool_act;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic signed [23:0] in_data = '0;
  logic               rdy4, ov4;
  logic signed [15:0] od4;

  logic               v1 = 1'b0, l1 = 1'b0, ordy1 = 1'b0;
  logic signed [23:0] d1 = '0;
  logic               rdy1, ov1;
  logic signed [15:0] od1;

  int errors = 0;
  int checks = 0;
  int win_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  macc_pool_act #(.IN_WIDTH(24), .OUT_WIDTH(16), .POOL_SIZE(4)) dut4 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_last(in_last), .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
  );

  macc_pool_act #(.IN_WIDTH(24), .OUT_WIDTH(16), .POOL_SIZE(1)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_last(l1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1)
  );

  function automatic int act_sat(input int m);
    int r;
    r = m;
`ifdef MACC_POOL_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int rand24();
    int r;
    r = int'($urandom_range(0, 16777215));
    return r - 8388608;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 24'(v);
    in_last  = last;
    @(negedge clk);
    while (!rdy4 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy4) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the POOL_SIZE=4 instance: windows from sample order, one result per close.
  always @(negedge clk) begin
    if (!rst_n) begin
      win_q.delete();
      exp_q.delete();
    end else begin
      chk("valid_tracks_model", int'(ov4), int'(exp_q.size() > 0));
      if (ov4 && out_ready) begin
        chk("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("sb_out", int'(od4), exp_q.pop_front());
      end
      if (in_valid && rdy4) begin : accept_blk
        int m;
        win_q.push_back(int'(in_data));
        if (in_last || win_q.size() == 4) begin
          m = win_q[0];
          foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
          exp_q.push_back(act_sat(m));
          win_q.delete();
        end
      end
    end
  end

  initial begin
    int r[4];
    int m;
    int x;
    int hold_exp;
    bit pend;
    int nxt_in, nxt_out;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(ov4), 0);
    chk("rst_out_data", int'(od4), 0);
    chk("rst_in_ready", int'(rdy4), 0);
    chk("rst_in_ready_p1", int'(rdy1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", int'(rdy4), 1);
    cycle();

    // Pool basic
    out_ready = 1'b1;
    send(3, 1'b0);   chk("basic_no_out1", int'(ov4), 0);
    send(-7, 1'b0);  chk("basic_no_out2", int'(ov4), 0);
    send(12, 1'b0);  chk("basic_no_out3", int'(ov4), 0);
    send(5, 1'b0);
    chk("basic_valid", int'(ov4), 1);
    chk("basic_data", int'(od4), 12);

    // Saturation
    send(40000, 1'b0); send(1, 1'b0); send(2, 1'b0); send(3, 1'b0);
    chk("sat_pos", int'(od4), 32767);
    send(-50000, 1'b0); send(-60000, 1'b0); send(-40000, 1'b0); send(-70000, 1'b0);
`ifdef MACC_POOL_RELU_EN
    chk("sat_neg", int'(od4), 0);
`else
    chk("sat_neg", int'(od4), -32768);
`endif

    // Early close, then a fresh full window
    send(-4, 1'b0);
    send(-9, 1'b1);
    chk("early_valid", int'(ov4), 1);
`ifdef MACC_POOL_RELU_EN
    chk("early_data", int'(od4), 0);
`else
    chk("early_data", int'(od4), -4);
`endif
    foreach (r[i]) r[i] = rand24();
    for (int i = 0; i < 4; i++) begin
      send(r[i], 1'b0);
      if (i < 3) chk("fresh_no_out", int'(ov4), 0);
    end
    m = r[0];
    foreach (r[i]) if (r[i] > m) m = r[i];
    chk("fresh_data", int'(od4), act_sat(m));

    // Backpressure: hold, then drain concurrently with a one-sample closing window
    foreach (r[i]) r[i] = rand24();
    for (int i = 0; i < 4; i++) send(r[i], 1'b0);
    m = r[0];
    foreach (r[i]) if (r[i] > m) m = r[i];
    hold_exp = act_sat(m);
    out_ready = 1'b0;
    x = rand24();
    in_valid = 1'b1;
    in_data  = 24'(x);
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(rdy4), 0);
      chk("bp_valid", int'(ov4), 1);
      chk("bp_hold", int'(od4), hold_exp);
      cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(rdy4), 1);
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("b2b_valid", int'(ov4), 1);
    chk("b2b_data", int'(od4), act_sat(x));
    cycle();
    chk("b2b_drained", int'(ov4), 0);

    // Randomized stream with random backpressure and ragged windows
    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend     = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'(rand24());
        in_last  = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      if (in_valid && rdy4) pend = 1'b0;
      cycle();
      if (!pend) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    out_ready = 1'b1;
    send(rand24(), 1'b1);
    cycle();
    cycle();
    chk("rand_drain_empty", exp_q.size(), 0);
    chk("rand_drain_valid", int'(ov4), 0);

    // POOL_SIZE=1: every sample is its own window
    nxt_in  = 1;
    nxt_out = 1;
    for (int c = 0; c < 200 && nxt_out <= 8; c++) begin
      ordy1 = $urandom_range(0, 1);
      v1    = (nxt_in <= 8);
      d1    = 24'(nxt_in);
      l1    = $urandom_range(0, 1);
      @(negedge clk);
      if (ov1 && ordy1) begin
        chk("p1_out", int'(od1), nxt_out);
        nxt_out++;
      end
      if (v1 && rdy1) nxt_in++;
      cycle();
    end
    v1 = 1'b0;
    chk("p1_count", nxt_out, 9);

    // Reset mid-window discards the partial window
    out_ready = 1'b1;
    send(7000, 1'b0);
    send(8000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(ov4), 0);
    chk("midrst_ready", int'(rdy4), 0);
    cycle();
    rst_n = 1'b1;
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
    chk("postrst_valid", int'(ov4), 1);
    chk("postrst_data", int'(od4), 4);
    cycle();
    chk("postrst_drained", int'(ov4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
